// File: rtl/aes_pkg.sv
// Shared AES types, FSM encodings and GF(2^8) helpers used by the
// MixColumns datapath.
package aes_pkg;

    typedef enum logic [1:0] {
        CIPH_FWD = 2'b01,
        CIPH_INV = 2'b10
    } ciph_op_e;

    // One-hot encodings so a single upset lands on an illegal value.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        BUSY = 3'b010,
        DONE = 3'b100
    } mix_iter_state_e;

    localparam int MixColCntW = 2;

    typedef logic [3:0][3:0][7:0] aes_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a small constant (at most 4 bits), as MixColumns needs.
    function automatic logic [7:0] gf_mul_c(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] x1;
        logic [7:0] x2;
        logic [7:0] x3;
        x1 = xtime(a);
        x2 = xtime(x1);
        x3 = xtime(x2);
        return (b[0] ? a : 8'h00) ^ (b[1] ? x1 : 8'h00) ^
               (b[2] ? x2 : 8'h00) ^ (b[3] ? x3 : 8'h00);
    endfunction

endpackage

// File: rtl/aes_mix_single_column.sv
// Combinational MixColumns / InvMixColumns on one 4-byte column.
module aes_mix_single_column
    import aes_pkg::*;
(
    input  ciph_op_e         op_i,
    input  logic [3:0][7:0]  data_i,
    output logic [3:0][7:0]  data_o
);

    logic [3:0][7:0] w_fwd;
    logic [3:0][7:0] w_inv;

    for (genvar r = 0; r < 4; r++) begin : g_row
        assign w_fwd[r] = gf_mul_c(data_i[r], 4'd2) ^ gf_mul_c(data_i[(r + 1) % 4], 4'd3) ^
                          data_i[(r + 2) % 4] ^ data_i[(r + 3) % 4];
        assign w_inv[r] = gf_mul_c(data_i[r], 4'd14) ^ gf_mul_c(data_i[(r + 1) % 4], 4'd11) ^
                          gf_mul_c(data_i[(r + 2) % 4], 4'd13) ^ gf_mul_c(data_i[(r + 3) % 4], 4'd9);
    end

    assign data_o = (op_i == CIPH_INV) ? w_inv : w_fwd;

endmodule

// File: rtl/aes_mix_columns_iter.sv
// Iterative MixColumns engine: ColsPerCycle columns are transformed in place
// each BUSY cycle; one block in flight, valid/ready on both sides.
module aes_mix_columns_iter
    import aes_pkg::*;
#(
    parameter int ColsPerCycle = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  ciph_op_e               op_i,
    input  logic [3:0][3:0][7:0]   state_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [3:0][3:0][7:0]   state_o,
    output logic                   err_o,
    output logic                   busy_o
);

    localparam int Latency = 4 / ColsPerCycle;
    localparam logic [MixColCntW-1:0] ColStep = MixColCntW'(ColsPerCycle);
    localparam logic [MixColCntW-1:0] LastCol = MixColCntW'((Latency - 1) * ColsPerCycle);

    if (ColsPerCycle != 1 && ColsPerCycle != 2 && ColsPerCycle != 4) begin : g_bad_param
        $fatal(1, "aes_mix_columns_iter: ColsPerCycle must be 1, 2 or 4");
    end

    mix_iter_state_e        r_fsm;
    logic [MixColCntW-1:0]  r_col_cnt;
    logic [3:0][3:0][7:0]   r_state;
    ciph_op_e               r_op;
    logic                   r_err;

    logic                   w_in_ready;
    logic                   w_op_ok;
    logic [3:0][3:0][7:0]   w_state_nxt;
    logic [3:0][7:0]        w_col_in  [ColsPerCycle];
    logic [3:0][7:0]        w_col_out [ColsPerCycle];

    for (genvar g = 0; g < ColsPerCycle; g++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_mux
            assign w_col_in[g][r] = r_state[r][r_col_cnt + MixColCntW'(g)];
        end
        aes_mix_single_column u_col (
            .op_i   (r_op),
            .data_i (w_col_in[g]),
            .data_o (w_col_out[g])
        );
    end

    // Groups are always aligned to ColsPerCycle, so each column maps to a fixed lane.
    for (genvar c = 0; c < 4; c++) begin : g_wb
        localparam logic [MixColCntW-1:0] Base = MixColCntW'((c / ColsPerCycle) * ColsPerCycle);
        logic w_hit;
        assign w_hit = (r_col_cnt == Base);
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_state_nxt[r][c] = w_hit ? w_col_out[c % ColsPerCycle][r] : r_state[r][c];
        end
    end

    assign w_op_ok    = (op_i == CIPH_FWD) || (op_i == CIPH_INV);
    assign w_in_ready = (r_fsm == IDLE) && !clear_i && !rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fsm     <= IDLE;
            r_col_cnt <= '0;
            r_state   <= '0;
            r_op      <= CIPH_FWD;
            r_err     <= 1'b0;
        end else if (clear_i) begin
            r_fsm     <= IDLE;
            r_col_cnt <= '0;
            r_state   <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid_i && w_in_ready) begin
                        // A bad op loads zeros so the raw input never reaches state_o.
                        r_state   <= w_op_ok ? state_i : '0;
                        r_op      <= op_i;
                        r_err     <= !w_op_ok;
                        r_col_cnt <= '0;
                        r_fsm     <= BUSY;
                    end
                end
                BUSY: begin
                    r_state   <= w_state_nxt;
                    r_col_cnt <= r_col_cnt + ColStep;
                    if (r_col_cnt == LastCol) begin
                        r_fsm <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        r_fsm <= IDLE;
                    end
                end
                default: begin
                    r_fsm     <= IDLE;
                    r_col_cnt <= '0;
                    r_state   <= '0;
                    r_err     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = (r_fsm == DONE);
    assign err_o       = out_valid_o && r_err;
    assign busy_o      = (r_fsm != IDLE);
    assign state_o     = r_state;

endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// Bench for aes_mix_columns_iter: three instances (1, 2 and 4 columns per
// cycle) checked against a GF(2^8) matrix-product model of MixColumns.
module tb_aes_mix_columns_iter;
  import aes_pkg::*;

  logic clk;
  logic rst;

  logic       clear     [3];
  logic       in_valid  [3];
  logic       in_ready  [3];
  ciph_op_e   op_in     [3];
  aes_state_t st_in     [3];
  logic       out_valid [3];
  logic       out_ready [3];
  aes_state_t st_out    [3];
  logic       err       [3];
  logic       busy      [3];

  int cpc_of [3] = '{1, 2, 4};

  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] exp_q[$];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int Cpc = (k == 0) ? 1 : (k == 1) ? 2 : 4;
    aes_mix_columns_iter #(.ColsPerCycle(Cpc)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .clear_i     (clear[k]),
      .in_valid_i  (in_valid[k]),
      .in_ready_o  (in_ready[k]),
      .op_i        (op_in[k]),
      .state_i     (st_in[k]),
      .out_valid_o (out_valid[k]),
      .out_ready_i (out_ready[k]),
      .state_o     (st_out[k]),
      .err_o       (err[k]),
      .busy_o      (busy[k])
    );
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: plain polynomial multiply then reduce by x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++)
      if (((b >> i) & 1) != 0) p = p ^ (int'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (((p >> i) & 1) != 0) p = p ^ (32'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic aes_state_t ref_mix(input ciph_op_e op, input aes_state_t s);
    int fwd [4] = '{2, 3, 1, 1};
    int inv [4] = '{14, 11, 13, 9};
    aes_state_t o;
    logic [7:0] v;
    o = '0;
    if (op != CIPH_FWD && op != CIPH_INV) return o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        v = 8'h00;
        for (int j = 0; j < 4; j++)
          v = v ^ gmul(s[j][c], (op == CIPH_FWD) ? fwd[(j - r + 4) % 4] : inv[(j - r + 4) % 4]);
        o[r][c] = v;
      end
    return o;
  endfunction

  function automatic aes_state_t from_cols(input logic [31:0] c0, input logic [31:0] c1,
                                           input logic [31:0] c2, input logic [31:0] c3);
    aes_state_t s;
    logic [31:0] w [4];
    w[0] = c0; w[1] = c1; w[2] = c2; w[3] = c3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = w[c][31 - 8 * r -: 8];
    return s;
  endfunction

  function automatic aes_state_t rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // driver: one full block with optional backpressure, checked against exp_q
  task automatic run_block(input int k, input ciph_op_e op, input aes_state_t st,
                           input aes_state_t exp, input logic exp_err, input int bp);
    int cycles;
    aes_state_t held;
    @(negedge clk);
    in_valid[k] = 1'b1;
    op_in[k]    = op;
    st_in[k]    = st;
    out_ready[k] = 1'b0;
    #1 check_eq($sformatf("acc_rdy%0d", k), 128'(in_ready[k]), 128'(1));
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    st_in[k]    = rand_state();
    op_in[k]    = ($urandom_range(0, 1) == 0) ? CIPH_FWD : CIPH_INV;
    cycles = 0;
    while (out_valid[k] !== 1'b1 && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check_eq($sformatf("lat%0d", k), 128'(cycles), 128'(4 / cpc_of[k]));
    held = exp_q.pop_front();
    check_eq($sformatf("state%0d", k), st_out[k], held);
    check_eq($sformatf("err%0d", k), 128'(err[k]), 128'(exp_err));
    check_eq($sformatf("busy_rdy%0d", k), 128'(in_ready[k]), 128'(0));
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp_state", st_out[k], held);
      check_eq("bp_valid", 128'(out_valid[k]), 128'(1));
      check_eq("bp_err", 128'(err[k]), 128'(exp_err));
      check_eq("bp_rdy", 128'(in_ready[k]), 128'(0));
    end
    out_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[k] = 1'b0;
    check_eq($sformatf("drop_valid%0d", k), 128'(out_valid[k]), 128'(0));
    check_eq($sformatf("idle%0d", k), 128'(busy[k]), 128'(0));
    check_eq($sformatf("idle_rdy%0d", k), 128'(in_ready[k]), 128'(1));
  endtask

  aes_state_t fips_in;
  aes_state_t fips_out;
  aes_state_t s;
  ciph_op_e   op;
  int         sel;
  int         kk;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      clear[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
      op_in[k] = CIPH_FWD; st_in[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_valid", 128'(out_valid[k]), 128'(0));
      check_eq("rst_state", st_out[k], 128'(0));
      check_eq("rst_err", 128'(err[k]), 128'(0));
      check_eq("rst_busy", 128'(busy[k]), 128'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) check_eq("rst_rdy", 128'(in_ready[k]), 128'(1));

    // known-answer vector, forward with backpressure, then inverse on every width
    fips_in  = from_cols(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);
    fips_out = from_cols(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6);
    run_block(0, CIPH_FWD, fips_in, fips_out, 1'b0, 10);
    for (int k = 0; k < 3; k++) run_block(k, CIPH_INV, fips_out, fips_in, 1'b0, 0);

    // clear during the second BUSY cycle, with a competing input
    @(negedge clk);
    in_valid[0] = 1'b1; op_in[0] = CIPH_FWD; st_in[0] = fips_in;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    clear[0] = 1'b1; in_valid[0] = 1'b1; st_in[0] = rand_state();
    #1 check_eq("clr_rdy", 128'(in_ready[0]), 128'(0));
    @(posedge clk);
    #1;
    clear[0] = 1'b0; in_valid[0] = 1'b0;
    check_eq("clr_busy", 128'(busy[0]), 128'(0));
    check_eq("clr_valid", 128'(out_valid[0]), 128'(0));
    check_eq("clr_state", st_out[0], 128'(0));
    check_eq("clr_err", 128'(err[0]), 128'(0));
    @(posedge clk);
    #1 check_eq("clr_noacc", 128'(busy[0]), 128'(0));
    s = rand_state();
    run_block(0, CIPH_FWD, s, ref_mix(CIPH_FWD, s), 1'b0, 1);

    // invalid op on every width
    s = '1;
    for (int k = 0; k < 3; k++) run_block(k, ciph_op_e'(2'b11), s, '0, 1'b1, 2);

    // asynchronous reset mid-BUSY, no clock edge before checking
    @(negedge clk);
    in_valid[1] = 1'b1; op_in[1] = CIPH_INV; st_in[1] = rand_state();
    @(posedge clk);
    #1 in_valid[1] = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("arst_busy", 128'(busy[1]), 128'(0));
    check_eq("arst_valid", 128'(out_valid[1]), 128'(0));
    check_eq("arst_state", st_out[1], 128'(0));
    @(negedge clk);
    rst = 1'b0;
    s = rand_state();
    run_block(1, CIPH_FWD, s, ref_mix(CIPH_FWD, s), 1'b0, 0);

    // randomized traffic
    for (int n = 0; n < 30; n++) begin
      kk  = $urandom_range(0, 2);
      sel = $urandom_range(0, 7);
      op  = (sel == 0) ? ciph_op_e'(2'b00) : (sel == 1) ? ciph_op_e'(2'b11) :
            (sel[0] ? CIPH_FWD : CIPH_INV);
      s   = rand_state();
      run_block(kk, op, s, ref_mix(op, s), (sel <= 1), $urandom_range(0, 3));
    end

    check_eq("sb_empty", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
